// File: rtl/soc_bus_fabric.sv
// Address decoder, read-data mux and wait-state/timeout sequencer for the 6502-family SoC bus.
// Latency: zero-wait slaves complete in the address cycle; read data reaches cpu_di one cycle after completion.
// Backpressure: cpu_rdy is held low for programmed wait states and slave not-ready, capped at TIMEOUT stall cycles.
module soc_bus_fabric #(
    parameter int                          NSLAVE    = 4,
    parameter int                          ADDR_W    = 16,
    parameter int                          DATA_W    = 8,
    parameter int                          PAGE_BITS = 4,
    parameter logic [NSLAVE*PAGE_BITS-1:0] SLV_BASE  = {4'hF, 4'h2, 4'h1, 4'h0},
    parameter logic [NSLAVE*PAGE_BITS-1:0] SLV_MASK  = '1,
    parameter logic [NSLAVE*4-1:0]         SLV_WAIT  = '0,
    parameter int                          TIMEOUT   = 32,
    parameter logic [DATA_W-1:0]           ERR_DATA  = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          cpu_ab,
    input  logic                       cpu_we,
    output logic [DATA_W-1:0]          cpu_di,
    output logic                       cpu_rdy,
    output logic [NSLAVE-1:0]          slv_cs,
    output logic [NSLAVE-1:0]          slv_wstb,
    input  logic [NSLAVE*DATA_W-1:0]   slv_do,
    input  logic [NSLAVE-1:0]          slv_ready,
    input  logic                       err_clr,
    output logic                       bus_err,
    output logic [4:0]                 err_id
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  wcnt, wcnt_nxt;
    logic [7:0]  tcnt, tcnt_nxt;
    logic [3:0]  s_lat, s_nxt;

    logic              hit;
    logic [3:0]        sel;
    logic [3:0]        sel_wait;
    logic              sel_rdy;
    logic              lat_rdy;
    logic [NSLAVE-1:0] cs_dec;
    logic              rdy;
    logic              normal;
    logic              forced;

    logic              rd_vld;
    logic [3:0]        rd_idx;

    // Low address bits take no part in decode.
    logic unused_ab;
    assign unused_ab = ^cpu_ab[ADDR_W-PAGE_BITS-1:0];

    // Page decode; descending scan so the lowest matching index wins.
    always_comb begin
        hit      = 1'b0;
        sel      = '0;
        sel_wait = '0;
        sel_rdy  = 1'b0;
        for (int i = NSLAVE - 1; i >= 0; i--) begin
            if (((cpu_ab[ADDR_W-1 -: PAGE_BITS] ^ SLV_BASE[i*PAGE_BITS +: PAGE_BITS])
                 & SLV_MASK[i*PAGE_BITS +: PAGE_BITS]) == '0) begin
                hit      = 1'b1;
                sel      = 4'(i);
                sel_wait = SLV_WAIT[i*4 +: 4];
                sel_rdy  = slv_ready[i];
            end
        end
    end

    // One-hot chip selects and the ready of the slave latched at stall entry.
    always_comb begin
        cs_dec  = '0;
        lat_rdy = 1'b0;
        for (int i = 0; i < NSLAVE; i++) begin
            cs_dec[i] = hit && (sel == 4'(i));
            if (s_lat == 4'(i)) lat_rdy = slv_ready[i];
        end
    end

    // Next-state, counters and completion for the IDLE/WAIT sequencer.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        tcnt_nxt  = tcnt;
        s_nxt     = s_lat;
        rdy       = 1'b1;
        normal    = 1'b0;
        forced    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hit && !(sel_wait == 4'd0 && sel_rdy)) begin
                    rdy       = 1'b0;
                    state_nxt = ST_WAIT;
                    wcnt_nxt  = (sel_wait != 4'd0) ? 4'(sel_wait - 4'd1) : 4'd0;
                    tcnt_nxt  = 8'd0;
                    s_nxt     = sel;
                end
            end
            ST_WAIT: begin
                normal   = (wcnt == 4'd0) && lat_rdy;
                forced   = !normal && (tcnt == 8'(TIMEOUT - 1));
                rdy      = normal || forced;
                wcnt_nxt = (wcnt == 4'd0) ? 4'd0 : 4'(wcnt - 4'd1);
                tcnt_nxt = tcnt + 8'd1;
                if (rdy) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            wcnt  <= '0;
            tcnt  <= '0;
            s_lat <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            tcnt  <= tcnt_nxt;
            s_lat <= s_nxt;
        end
    end

    // Capture which slave's registered data the CPU sees after each completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld <= 1'b0;
            rd_idx <= '0;
        end else if (rdy) begin
            rd_vld <= hit && !forced;
            rd_idx <= sel;
        end
    end

    // Sticky error flag; a new error takes priority over a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err <= 1'b0;
            err_id  <= '0;
        end else if (rdy && !hit) begin
            bus_err <= 1'b1;
            err_id  <= 5'h10;
        end else if (forced) begin
            bus_err <= 1'b1;
            err_id  <= {1'b0, s_lat};
        end else if (err_clr) begin
            bus_err <= 1'b0;
        end
    end

    // Read-data mux; unmapped, timed-out or in-reset returns ERR_DATA.
    always_comb begin
        cpu_di = ERR_DATA;
        if (rd_vld && !reset) begin
            for (int i = 0; i < NSLAVE; i++) begin
                if (rd_idx == 4'(i)) cpu_di = slv_do[i*DATA_W +: DATA_W];
            end
        end
    end

    assign cpu_rdy  = rdy | reset;
    assign slv_cs   = reset ? '0 : cs_dec;
    assign slv_wstb = cs_dec & {NSLAVE{cpu_we & rdy & ~forced & ~reset}};

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Self-checking bench for soc_bus_fabric: table vectors plus wait, timeout, reset and overlap sequences.
// Latency: one vector per clock; read data checked one cycle after each completion via a queue.
// Backpressure: slv_ready patterns stall the DUT; all sequences are fixed length.
module tb_soc_bus_fabric;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_ab;
    logic        cpu_we;
    logic        err_clr;
    logic [7:0]  cpu_di;
    logic        cpu_rdy;
    logic [3:0]  slv_cs, slv_wstb, slv_ready;
    logic [31:0] slv_do;
    logic        bus_err;
    logic [4:0]  err_id;

    logic [7:0]  ov_di;
    logic        ov_rdy;
    logic [1:0]  ov_cs, ov_wstb;
    logic [15:0] ov_do;
    logic [1:0]  ov_ready;
    logic        ov_err;
    logic [4:0]  ov_id;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  sb[$];

    always #5 clk = ~clk;

    assign slv_do   = {8'h22, 8'h33, 8'h44, 8'h11};
    assign ov_do    = {8'hB1, 8'hB0};
    assign ov_ready = 2'b11;

    soc_bus_fabric #(
        .SLV_WAIT (16'h0030),
        .TIMEOUT  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_ab    (cpu_ab),
        .cpu_we    (cpu_we),
        .cpu_di    (cpu_di),
        .cpu_rdy   (cpu_rdy),
        .slv_cs    (slv_cs),
        .slv_wstb  (slv_wstb),
        .slv_do    (slv_do),
        .slv_ready (slv_ready),
        .err_clr   (err_clr),
        .bus_err   (bus_err),
        .err_id    (err_id)
    );

    soc_bus_fabric #(
        .NSLAVE   (2),
        .SLV_BASE (8'h10),
        .SLV_MASK (8'hF0),
        .SLV_WAIT (8'h00)
    ) dut_ov (
        .clk       (clk),
        .reset     (reset),
        .cpu_ab    (cpu_ab),
        .cpu_we    (cpu_we),
        .cpu_di    (ov_di),
        .cpu_rdy   (ov_rdy),
        .slv_cs    (ov_cs),
        .slv_wstb  (ov_wstb),
        .slv_do    (ov_do),
        .slv_ready (ov_ready),
        .err_clr   (err_clr),
        .bus_err   (ov_err),
        .err_id    (ov_id)
    );

    typedef struct {
        logic [15:0] ab;
        logic        we;
        logic [3:0]  rdy_in;
        logic        exp_rdy;
        logic [3:0]  exp_cs;
        logic [3:0]  exp_wstb;
        logic [7:0]  exp_nd;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // One bus cycle: drive, sample at negedge, check, queue next-cycle read data.
    task automatic step(input logic [15:0] ab, input logic we, input logic [3:0] rdy_in,
                        input logic exp_rdy, input logic [3:0] exp_cs, input logic [3:0] exp_wstb,
                        input logic [7:0] exp_nd, input string nm);
        cpu_ab    = ab;
        cpu_we    = we;
        slv_ready = rdy_in;
        @(negedge clk);
        chk({nm, ".rdy"}, 32'(cpu_rdy), 32'(exp_rdy));
        chk({nm, ".cs"}, 32'(slv_cs), 32'(exp_cs));
        chk({nm, ".wstb"}, 32'(slv_wstb), 32'(exp_wstb));
        if (sb.size() > 0) chk({nm, ".di"}, 32'(cpu_di), 32'(sb.pop_front()));
        if (exp_rdy) sb.push_back(exp_nd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{16'h0123, 1'b0, 4'hF,    1'b1, 4'b0001, 4'b0000, 8'h11};
        tbl[1]  = '{16'hF000, 1'b0, 4'hF,    1'b1, 4'b1000, 4'b0000, 8'h22};
        tbl[2]  = '{16'h2000, 1'b0, 4'b1011, 1'b0, 4'b0100, 4'b0000, 8'h00};
        tbl[3]  = '{16'h2000, 1'b0, 4'b1011, 1'b0, 4'b0100, 4'b0000, 8'h00};
        tbl[4]  = '{16'h2000, 1'b0, 4'b1011, 1'b0, 4'b0100, 4'b0000, 8'h00};
        tbl[5]  = '{16'h2000, 1'b0, 4'b1011, 1'b0, 4'b0100, 4'b0000, 8'h00};
        tbl[6]  = '{16'h2000, 1'b0, 4'b1011, 1'b0, 4'b0100, 4'b0000, 8'h00};
        tbl[7]  = '{16'h2000, 1'b0, 4'hF,    1'b1, 4'b0100, 4'b0000, 8'h33};
        tbl[8]  = '{16'h0001, 1'b1, 4'hF,    1'b1, 4'b0001, 4'b0001, 8'h11};
        tbl[9]  = '{16'h5000, 1'b0, 4'hF,    1'b1, 4'b0000, 4'b0000, 8'hFF};
        tbl[10] = '{16'h0123, 1'b0, 4'hF,    1'b1, 4'b0001, 4'b0000, 8'h11};

        // Reset held with a write to a wait-state slave pending.
        reset     = 1'b1;
        cpu_ab    = 16'h1004;
        cpu_we    = 1'b1;
        err_clr   = 1'b0;
        slv_ready = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.rdy", 32'(cpu_rdy), 32'd1);
        chk("rst.cs", 32'(slv_cs), 32'd0);
        chk("rst.wstb", 32'(slv_wstb), 32'd0);
        chk("rst.di", 32'(cpu_di), 32'hFF);
        chk("rst.err", 32'(bus_err), 32'd0);
        chk("rst.id", 32'(err_id), 32'd0);
        chk("rst.ov_cs", 32'(ov_cs), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.push_back(8'hFF);

        // Zero-wait reads, slave-ready stall, write, unmapped access.
        for (int i = 0; i < 11; i++)
            step(tbl[i].ab, tbl[i].we, tbl[i].rdy_in, tbl[i].exp_rdy, tbl[i].exp_cs,
                 tbl[i].exp_wstb, tbl[i].exp_nd, $sformatf("vec%0d", i));
        chk("unmap.err", 32'(bus_err), 32'd1);
        chk("unmap.id", 32'(err_id), 32'h10);

        err_clr = 1'b1;
        step(16'h0123, 1'b0, 4'hF, 1'b1, 4'b0001, 4'b0000, 8'h11, "clr");
        err_clr = 1'b0;
        chk("clr.err", 32'(bus_err), 32'd0);
        chk("clr.id", 32'(err_id), 32'h10);

        // Three programmed wait states on slave 1: strobe only on the completing cycle.
        for (int i = 0; i < 3; i++)
            step(16'h1004, 1'b1, 4'hF, 1'b0, 4'b0010, 4'b0000, 8'h00, $sformatf("ws%0d", i));
        step(16'h1004, 1'b1, 4'hF, 1'b1, 4'b0010, 4'b0010, 8'h44, "ws3");

        // Slave 0 never ready: forced completion after 8 stall cycles, no strobe.
        for (int i = 0; i < 8; i++)
            step(16'h0000, 1'b1, 4'b1110, 1'b0, 4'b0001, 4'b0000, 8'h00, $sformatf("to%0d", i));
        step(16'h0000, 1'b1, 4'b1110, 1'b1, 4'b0001, 4'b0000, 8'hFF, "to8");
        chk("to.err", 32'(bus_err), 32'd1);
        chk("to.id", 32'(err_id), 32'h00);
        step(16'h0123, 1'b0, 4'hF, 1'b1, 4'b0001, 4'b0000, 8'h11, "after_to0");
        step(16'h0124, 1'b0, 4'hF, 1'b1, 4'b0001, 4'b0000, 8'h11, "after_to1");

        // Reset in the middle of a stall.
        step(16'h1004, 1'b1, 4'hF, 1'b0, 4'b0010, 4'b0000, 8'h00, "mid0");
        reset = 1'b1;
        @(negedge clk);
        chk("mid.rdy", 32'(cpu_rdy), 32'd1);
        chk("mid.cs", 32'(slv_cs), 32'd0);
        chk("mid.wstb", 32'(slv_wstb), 32'd0);
        chk("mid.di", 32'(cpu_di), 32'hFF);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        sb.push_back(8'hFF);
        chk("mid.err", 32'(bus_err), 32'd0);
        for (int i = 0; i < 3; i++)
            step(16'h1004, 1'b1, 4'hF, 1'b0, 4'b0010, 4'b0000, 8'h00, $sformatf("rws%0d", i));
        step(16'h1004, 1'b1, 4'hF, 1'b1, 4'b0010, 4'b0010, 8'h44, "rws3");

        // Overlapping decode: slave 0 matches everything and wins.
        cpu_ab = 16'h1000;
        cpu_we = 1'b0;
        @(negedge clk);
        chk("ov.cs", 32'(ov_cs), 32'h1);
        chk("ov.rdy", 32'(ov_rdy), 32'd1);
        chk("ov.wstb", 32'(ov_wstb), 32'd0);
        @(posedge clk);
        #1;
        cpu_ab = 16'h5000;
        @(negedge clk);
        chk("ov.di", 32'(ov_di), 32'hB0);
        chk("ov.cs2", 32'(ov_cs), 32'h1);
        chk("ov.err", 32'(ov_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
